// File: rtl/rv32i_lsu_pkg.sv
// Shared types and helpers for the RV32I load/store sequencer.
// Holds the funct3 and state encodings, the default memory depth and the
// size/lane-mask helpers used both at request accept and in the align logic.
package rv32i_lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 256;

  // RV32I load/store width encodings (stores use LB/LH/LW codes as SB/SH/SW)
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  // Access size in bytes from funct3[1:0]; 11 is illegal and is faulted elsewhere
  function automatic logic [2:0] access_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Seven-lane byte mask spanning the addressed word and the next one
  function automatic logic [6:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [6:0] base;
    case (sz)
      2'b00:   base = 7'b0000001;
      2'b01:   base = 7'b0000011;
      default: base = 7'b0001111;
    endcase
    return base << off;
  endfunction

  // Stores only allow the signed-width codes; loads additionally allow LBU/LHU
  function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      LB, LH, LW: return 1'b1;
      LBU, LHU:   return !we;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Combinational lane alignment for data_mem_ctrl.
// Produces the byte mask and lane-shifted store data for either word half of
// an access (hi selects the second word), and extracts/extends load data
// from the 64-bit capture buffer.
module data_mem_align
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        hi,
  input  logic [31:0] wdata,
  input  logic [63:0] load_buf,
  output logic [3:0]  half_mask,
  output logic [31:0] half_data,
  output logic [31:0] load_data
);

  logic [6:0]  wide_mask;
  logic [63:0] wide_data;
  logic [31:0] shifted;

  // Store side: build the two-word mask/data and pick the half being issued
  always_comb begin
    wide_mask = lane_mask(funct3[1:0], off);
    wide_data = {32'h0, wdata} << {off, 3'b000};
    half_mask = hi ? {1'b0, wide_mask[6:4]} : wide_mask[3:0];
    half_data = hi ? wide_data[63:32] : wide_data[31:0];
  end

  // Load side: right-justify the addressed bytes, then sign- or zero-extend
  always_comb begin
    shifted = 32'(load_buf >> {off, 3'b000});
    case (funct3)
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     load_data = {24'h0, shifted[7:0]};
      LHU:     load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the RV32I execute stage and a 32-bit-wide
// data memory with byte-masked synchronous write and combinational read.
// Optional feature macro: DATA_MEM_CTRL_SPLIT_EN -- when defined, accesses
// that cross a word boundary run as two back-to-back word accesses
// (ACC0 then ACC1); when undefined, any crossing access faults.
module data_mem_ctrl
  import rv32i_lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_fault,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_wr,
  output logic [3:0]       mem_mask,
  input  logic [31:0]      mem_rdata
);

  localparam logic [32:0] LAST_BYTE = 33'(4 * MEM_WORDS - 1);

  state_t state_reg, state_next;

  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [1:0]       off_reg;
  logic [31:0]      wdata_reg;
  logic             fault_reg;
  logic [31:0]      buf_lo_reg;
`ifdef DATA_MEM_CTRL_SPLIT_EN
  logic             cross_reg;
  logic [31:0]      buf_hi_reg;
`endif

  logic        accept;
  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic [6:0]  req_mask;
  logic        req_cross;
  logic        req_fault;
  logic        hi;
  logic [63:0] load_buf;
  logic [3:0]  half_mask;
  logic [31:0] half_data;
  logic [31:0] load_data;

  assign accept = (state_reg == IDLE) && req_valid;

  // Validate the incoming request: funct3, address range and word crossing
  always_comb begin
    req_size  = access_size(req_funct3[1:0]);
    req_last  = {1'b0, req_addr} + {30'h0, req_size} - 33'd1;
    req_mask  = lane_mask(req_funct3[1:0], req_addr[1:0]);
    req_cross = |req_mask[6:4];
`ifdef DATA_MEM_CTRL_SPLIT_EN
    req_fault = !funct3_legal(req_funct3, req_we) || (req_last > LAST_BYTE);
`else
    req_fault = !funct3_legal(req_funct3, req_we) || (req_last > LAST_BYTE) || req_cross;
`endif
  end

  // The second-word half is only ever selected while in ACC1
  assign hi = (state_reg == ACC1);

`ifdef DATA_MEM_CTRL_SPLIT_EN
  assign load_buf = {buf_hi_reg, buf_lo_reg};
`else
  assign load_buf = {32'h0, buf_lo_reg};
`endif

  data_mem_align u_align (
    .funct3    (funct3_reg),
    .off       (off_reg),
    .hi        (hi),
    .wdata     (wdata_reg),
    .load_buf  (load_buf),
    .half_mask (half_mask),
    .half_data (half_data),
    .load_data (load_data)
  );

  // State register; reset aborts any access in flight without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the request at accept and capture load data during each access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      idx_reg    <= '0;
      off_reg    <= 2'b00;
      wdata_reg  <= 32'h0;
      fault_reg  <= 1'b0;
      buf_lo_reg <= 32'h0;
`ifdef DATA_MEM_CTRL_SPLIT_EN
      cross_reg  <= 1'b0;
      buf_hi_reg <= 32'h0;
`endif
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      idx_reg    <= req_addr[IDX_W+1:2];
      off_reg    <= req_addr[1:0];
      wdata_reg  <= req_wdata;
      fault_reg  <= req_fault;
      buf_lo_reg <= 32'h0;
`ifdef DATA_MEM_CTRL_SPLIT_EN
      cross_reg  <= req_cross;
      buf_hi_reg <= 32'h0;
`endif
    end else if (state_reg == ACC0 && !we_reg) begin
      buf_lo_reg <= mem_rdata;
`ifdef DATA_MEM_CTRL_SPLIT_EN
    end else if (state_reg == ACC1 && !we_reg) begin
      buf_hi_reg <= mem_rdata;
`endif
    end
  end

  // Next-state and output decode; memory strobes stay low outside accesses
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_fault = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    mem_wr     = 1'b0;
    mem_mask   = 4'h0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ACC0;
      end
      ACC0: begin
        mem_addr  = idx_reg;
        mem_wdata = half_data;
        if (!fault_reg) begin
          mem_wr   = we_reg;
          mem_mask = half_mask;
        end
`ifdef DATA_MEM_CTRL_SPLIT_EN
        state_next = (cross_reg && !fault_reg) ? ACC1 : RESP;
`else
        state_next = RESP;
`endif
      end
`ifdef DATA_MEM_CTRL_SPLIT_EN
      ACC1: begin
        mem_addr   = idx_reg + IDX_W'(1);
        mem_wdata  = half_data;
        mem_wr     = we_reg;
        mem_mask   = half_mask;
        state_next = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_reg;
        resp_rdata = (!we_reg && !fault_reg) ? load_data : 32'h0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural 256x32 data memory.
// Expectations follow the build: DATA_MEM_CTRL_SPLIT_EN selects split results.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  logic        mem_init;
  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  // transaction results
  int          lat;
  int          wr_cnt;
  logic [31:0] a0_addr, a0_mask, a1_addr, a1_mask;
  logic [31:0] r_data, r_fault;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_mask   (mem_mask),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  // memory model: preload during init, else byte-masked write
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[255] <= 32'h12345678;
    end else if (mem_wr) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    @(negedge clk);
    check_eq("ready_before_req", {31'h0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wr_cnt = 0;
    a0_addr = 32'hFFFF_FFFF; a0_mask = 32'hFFFF_FFFF;
    a1_addr = 32'hFFFF_FFFF; a1_mask = 32'hFFFF_FFFF;
    r_data = 32'hFFFF_FFFF; r_fault = 32'hFFFF_FFFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
      if (k == 1) begin a0_addr = {24'h0, mem_addr}; a0_mask = {28'h0, mem_mask}; end
      if (k == 2 && !resp_valid) begin a1_addr = {24'h0, mem_addr}; a1_mask = {28'h0, mem_mask}; end
      if (resp_valid) begin
        lat = k; r_data = resp_rdata; r_fault = {31'h0, resp_fault};
        break;
      end
    end
    $display("txn we=%0d f3=%03b addr=%h wdata=%h lat=%0d wr=%0d rdata=%h fault=%0d",
             we, f3, addr, wd, lat, wr_cnt, r_data, r_fault);
  endtask

  int resp_cnt, ready_cnt, overlap;

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset state
    check_eq("rst_ready", {31'h0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_mem_wr", {31'h0, mem_wr}, 32'd0);
    check_eq("rst_mem_mask", {28'h0, mem_mask}, 32'd0);
    check_eq("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
    rst = 1'b0; mem_init = 1'b0;

    // SW / LW full word
    run_req(1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
    check_eq("sw_lat", lat, 2);
    check_eq("sw_addr", a0_addr, 32'd4);
    check_eq("sw_mask", a0_mask, 32'hF);
    check_eq("sw_wr", wr_cnt, 1);
    check_eq("sw_fault", r_fault, 0);
    check_eq("sw_rdata", r_data, 32'h0);
    check_eq("sw_mem4", mem[4], 32'hDEADBEEF);
    run_req(1'b0, 3'b010, 32'h010, 32'h0);
    check_eq("lw_lat", lat, 2);
    check_eq("lw_rdata", r_data, 32'hDEADBEEF);
    check_eq("lw_fault", r_fault, 0);
    check_eq("lw_wr", wr_cnt, 0);

    // SB / LB / LBU at lane 3
    run_req(1'b1, 3'b000, 32'h013, 32'h00000080);
    check_eq("sb_mask", a0_mask, 32'h8);
    check_eq("sb_mem4", mem[4], 32'h80ADBEEF);
    run_req(1'b0, 3'b000, 32'h013, 32'h0);
    check_eq("lb_rdata", r_data, 32'hFFFFFF80);
    run_req(1'b0, 3'b100, 32'h013, 32'h0);
    check_eq("lbu_rdata", r_data, 32'h00000080);

    // SH / LH crossing a word boundary
    run_req(1'b1, 3'b001, 32'h017, 32'h0000A55A);
`ifdef DATA_MEM_CTRL_SPLIT_EN
    check_eq("sh_x_lat", lat, 3);
    check_eq("sh_x_a0", a0_addr, 32'd5);
    check_eq("sh_x_m0", a0_mask, 32'h8);
    check_eq("sh_x_a1", a1_addr, 32'd6);
    check_eq("sh_x_m1", a1_mask, 32'h1);
    check_eq("sh_x_fault", r_fault, 0);
    check_eq("sh_x_mem5", mem[5], 32'h5A000000);
    check_eq("sh_x_mem6", mem[6], 32'h000000A5);
    run_req(1'b0, 3'b001, 32'h017, 32'h0);
    check_eq("lh_x_lat", lat, 3);
    check_eq("lh_x_rdata", r_data, 32'hFFFFA55A);
`else
    check_eq("sh_x_lat", lat, 2);
    check_eq("sh_x_fault", r_fault, 1);
    check_eq("sh_x_wr", wr_cnt, 0);
    check_eq("sh_x_mem5", mem[5], 32'h0);
    check_eq("sh_x_mem6", mem[6], 32'h0);
`endif

    // faults: out of range, illegal funct3 for load and store
    run_req(1'b0, 3'b010, 32'h3FE, 32'h0);
    check_eq("oor_fault", r_fault, 1);
    check_eq("oor_rdata", r_data, 32'h0);
    check_eq("oor_lat", lat, 2);
    run_req(1'b0, 3'b011, 32'h020, 32'h0);
    check_eq("f011_ld_fault", r_fault, 1);
    check_eq("f011_ld_rdata", r_data, 32'h0);
    run_req(1'b1, 3'b011, 32'h020, 32'hFFFFFFFF);
    check_eq("f011_st_fault", r_fault, 1);
    check_eq("f011_st_wr", wr_cnt, 0);
    check_eq("f011_st_mem8", mem[8], 32'h0);
    run_req(1'b1, 3'b100, 32'h024, 32'hFFFFFFFF);
    check_eq("f100_st_fault", r_fault, 1);
    check_eq("f100_st_wr", wr_cnt, 0);
    check_eq("f100_st_mem9", mem[9], 32'h0);

    // last legal bytes of memory
    run_req(1'b0, 3'b010, 32'h3FC, 32'h0);
    check_eq("lw_top_rdata", r_data, 32'h12345678);
    check_eq("lw_top_fault", r_fault, 0);
    run_req(1'b0, 3'b100, 32'h3FF, 32'h0);
    check_eq("lbu_top_rdata", r_data, 32'h00000012);
    check_eq("lbu_top_fault", r_fault, 0);

    // reset in the middle of a crossing store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h01E; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
`ifdef DATA_MEM_CTRL_SPLIT_EN
    check_eq("rstmid_a0", {24'h0, mem_addr}, 32'd7);
    check_eq("rstmid_m0", {28'h0, mem_mask}, 32'hC);
    check_eq("rstmid_wr0", {31'h0, mem_wr}, 32'd1);
`else
    check_eq("rstmid_wr0", {31'h0, mem_wr}, 32'd0);
`endif
    @(negedge clk);
`ifdef DATA_MEM_CTRL_SPLIT_EN
    check_eq("rstmid_a1", {24'h0, mem_addr}, 32'd8);
    check_eq("rstmid_m1", {28'h0, mem_mask}, 32'h3);
    check_eq("rstmid_nresp", {31'h0, resp_valid}, 32'd0);
`endif
    rst = 1'b1;
    #1;
    check_eq("rstmid_ready", {31'h0, req_ready}, 32'd1);
    check_eq("rstmid_resp", {31'h0, resp_valid}, 32'd0);
    check_eq("rstmid_wr", {31'h0, mem_wr}, 32'd0);
    check_eq("rstmid_mask", {28'h0, mem_mask}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check_eq("rstmid_no_resp", resp_cnt, 0);
`ifdef DATA_MEM_CTRL_SPLIT_EN
    check_eq("rstmid_mem7", mem[7], 32'hF00D0000);
`else
    check_eq("rstmid_mem7", mem[7], 32'h0);
`endif
    check_eq("rstmid_mem8", mem[8], 32'h0);
    $display("txn reset-abort store addr=0000001e mem7=%h mem8=%h", mem[7], mem[8]);

    // back-to-back requests with req_valid held high
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3FC;
    resp_cnt = 0; ready_cnt = 0; overlap = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++;
        check_eq("b2b_rdata", resp_rdata, 32'h12345678);
      end
      if (req_ready) ready_cnt++;
      if (req_ready && resp_valid) overlap++;
      if (n == 9) req_valid = 1'b0;
    end
    check_eq("b2b_resp_cnt", resp_cnt, 3);
    check_eq("b2b_ready_cnt", ready_cnt, 3);
    check_eq("b2b_overlap", overlap, 0);
    $display("txn back-to-back LW x3 responses=%0d", resp_cnt);
    @(negedge clk);
    check_eq("final_idle_ready", {31'h0, req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store sequencer between the RV32I execute stage and the word-organised data memory (256 x 32, byte-masked synchronous write, combinational read). Accepts one load or store per handshake, validates it, derives word index, byte mask and lane-shifted store data, and returns sign- or zero-extended load data. Accesses crossing a word boundary can optionally be split into two back-to-back word accesses.

## Interface
Parameters:
- MEM_WORDS, 256, depth of the data memory in 32-bit words.
- IDX_W, 8, word-index width; equals $clog2(MEM_WORDS).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  access rejected, valid with resp_valid.
- mem_addr  out  IDX_W  word index to memory.
- mem_wdata  out  32  lane-aligned store data.
- mem_wr  out  1  write strobe.
- mem_mask  out  4  byte-lane enables, bit n = bits [8n+7:8n].
- mem_rdata  in  32  combinational read data of mem_addr.

## Operation
- States: IDLE, ACC0, ACC1, RESP. Reset: IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_addr=0, mem_wdata=0, mem_wr=0, mem_mask=0.
- IDLE: req_valid && req_ready registers we, funct3, addr, wdata -> ACC0.
- size: 1/2/4 bytes for 00/01/10 of funct3[1:0]. off = addr[1:0]. wide_mask (7 bits) = ((1<<size)-1) << off; wide_data (64 bits) = wdata << 8*off.
- Fault (checked at accept, registered): funct3 illegal (011, 110, 111; any 1xx for store); addr+size-1 > 4*MEM_WORDS-1; crossing (wide_mask[6:4] != 0) when split disabled. Faulting request: ACC0 with mem_wr=0, mem_mask=0, no write, then RESP with resp_fault=1.
- ACC0: mem_addr = addr[IDX_W+1:2]; mem_mask = wide_mask[3:0]; mem_wdata = wide_data[31:0]; mem_wr = we. Load captures mem_rdata into low half of a 64-bit buffer. Next: ACC1 if crossing, else RESP.
- ACC1: mem_addr = first index + 1; mem_mask = {1'b0, wide_mask[6:4]}; mem_wdata = wide_data[63:32]; mem_wr = we. Load captures high half. Next: RESP.
- RESP: resp_valid=1; for loads, buffer >> 8*off, then LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW pass. -> IDLE.
- mem_wr and mem_mask are 0 outside ACC0/ACC1.

## Timing
- Accept at edge T. Non-crossing: ACC0 in cycle T+1, resp_valid in T+2. Crossing: ACC1 in T+2, resp_valid in T+3. Fault: resp_valid in T+2.
- Store bytes commit at the edge ending ACC0 (and ACC1).
- req_ready low from T+1 until return to IDLE; next request accepted no earlier than the resp_valid cycle's ending edge (throughput 1 per 3 or 4 cycles).
- rst mid-access: immediate return to IDLE, outputs to reset values, no response; a committed ACC0 half of a split store stays written, ACC1 half is not issued.

## Configuration
- DATA_MEM_CTRL_SPLIT_EN defined: crossing accesses take ACC0+ACC1 as above.
- Undefined: ACC1 state and high-half logic removed; any crossing access faults with no memory write.

## Structure
- Package rv32i_lsu_pkg: funct3 enum (LB..LHU), state enum, MEM_WORDS default, size/mask helper functions.
- Sub-module data_mem_align: combinational mask/shift generation and load extraction/extension; the FSM and registers stay in data_mem_ctrl.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 -> mem_mask 1111 on word 4; resp_rdata 0xDEADBEEF at T+2, fault 0.
- SB 0x80 @0x013, LB @0x013, LBU @0x013 -> mask 1000; resp_rdata 0xFFFFFF80 then 0x00000080.
- SH 0xA55A @0x017 with split enabled -> ACC0 word 5 mask 1000, ACC1 word 6 mask 0001; LH @0x017 returns 0xFFFFA55A at T+3. Split disabled -> resp_fault=1, no write.
- LW @0x3FE and funct3 011 -> resp_fault=1, resp_rdata 0, mem_wr never asserted.
- Assert rst during ACC1 of a split SW @0x01E -> word 7 high half written, word 8 unchanged, no resp_valid, req_ready=1 immediately.
- Back-to-back req_valid held high -> second accept only after resp_valid, each request gets exactly one response.
